// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-processor result path.
// Rounding in c_tile_drain is enabled by defining C_TILE_DRAIN_ROUND_EN.
package mm_pkg;

    typedef enum logic {
        IDLE,
        DRAIN
    } drain_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_B_N        = 4;
    localparam int DEF_N          = 1 << DEF_B_N;
    localparam int DEF_LANES      = 4;
    localparam int BEATS_PER_VEC  = DEF_N / DEF_LANES;

    // Processor accumulator width for a given output word width.
    function automatic int c_data_width(input int dw);
        return 2 * dw + 16;
    endfunction

endpackage

// File: rtl/c_tile_drain_requant_lane.sv
// Combinational requantizer for one C word: right shift, optional round-half-up
// (C_TILE_DRAIN_ROUND_EN), unsigned saturation to DATA_WIDTH.
module requant_lane #(
    parameter int DATA_WIDTH   = 8,
    parameter int C_DATA_WIDTH = 32,
    parameter int SHIFT_BITS   = 5
) (
    input  logic [C_DATA_WIDTH-1:0] x,
    input  logic [SHIFT_BITS-1:0]   shift,
    output logic [DATA_WIDTH-1:0]   y,
    output logic                    sat
);

    localparam int SW = C_DATA_WIDTH + 1;

    logic [SW-1:0] sum;
    logic [SW-1:0] shifted;

`ifdef C_TILE_DRAIN_ROUND_EN
    logic [SW-1:0] rnd;

    always_comb begin
        rnd = '0;
        if (shift != '0) begin
            rnd = SW'(1) << (shift - SHIFT_BITS'(1));
        end
    end

    assign sum = {1'b0, x} + rnd;
`else
    assign sum = {1'b0, x};
`endif

    assign shifted = sum >> shift;
    assign sat     = |shifted[SW-1:DATA_WIDTH];
    assign y       = sat ? '1 : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/c_tile_drain.sv
// Drain stage: accepts one N-word C vector per handshake, requantizes it and
// re-emits it as LANES-wide framed beats. Rounding: C_TILE_DRAIN_ROUND_EN.
module c_tile_drain
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int B_N          = 4,
    parameter int N            = 1 << B_N,
    parameter int C_DATA_WIDTH = c_data_width(DATA_WIDTH),
    parameter int LANES        = 4,
    parameter int SHIFT_BITS   = 5
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                dir_cfg,
    input  logic [SHIFT_BITS-1:0]               shift_amt,
    input  logic                                c_valid,
    output logic                                c_ready,
    output logic                                output_by_row,
    input  logic [N-1:0][C_DATA_WIDTH-1:0]      c_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [LANES-1:0][DATA_WIDTH-1:0]    m_data,
    output logic                                m_last,
    output logic [B_N-1:0]                      m_vec_idx,
    output logic                                sat_flag,
    output logic                                busy
);

    localparam int BEATS = N / LANES;
    localparam int LW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (N % LANES != 0) begin : g_chk_lanes
        $error("c_tile_drain: N must be a multiple of LANES");
    end
    if ((1 << SHIFT_BITS) > C_DATA_WIDTH) begin : g_chk_shift
        $error("c_tile_drain: 2**SHIFT_BITS must not exceed C_DATA_WIDTH");
    end

    drain_state_e state;

    logic [B_N-1:0]                               vec_cnt;
    logic [B_N-1:0]                               acc_idx;
    logic [LW-1:0]                                lane_cnt;
    logic                                         dir_reg;
    logic [SHIFT_BITS-1:0]                        shift_reg;
    logic [SHIFT_BITS-1:0]                        eff_shift;
    logic                                         sat_reg;
    logic [BEATS-1:0][LANES-1:0][DATA_WIDTH-1:0]  vbuf;
    logic [N-1:0][DATA_WIDTH-1:0]                 q_words;
    logic [N-1:0]                                 q_sat;
    logic                                         final_lane;
    logic                                         beat_hs;
    logic                                         accept;
    logic                                         first_acc;

    assign final_lane = (lane_cnt == LW'(BEATS - 1));
    assign beat_hs    = (state == DRAIN) && m_ready;
    assign c_ready    = (state == IDLE) || (beat_hs && final_lane);
    assign accept     = c_valid && c_ready;

    // Index the next accepted vector will take: in DRAIN it follows the one
    // being drained, so a back-to-back tile starts while vec_cnt is still N-1.
    assign acc_idx       = (state == DRAIN) ? vec_cnt + B_N'(1) : vec_cnt;
    assign first_acc     = (acc_idx == '0);
    assign eff_shift     = first_acc ? shift_amt : shift_reg;
    assign output_by_row = first_acc ? dir_cfg : dir_reg;

    for (genvar g = 0; g < N; g++) begin : g_lane
        requant_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .C_DATA_WIDTH(C_DATA_WIDTH),
            .SHIFT_BITS  (SHIFT_BITS)
        ) u_requant (
            .x    (c_data[g]),
            .shift(eff_shift),
            .y    (q_words[g]),
            .sat  (q_sat[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            vec_cnt   <= '0;
            lane_cnt  <= '0;
            dir_reg   <= 1'b0;
            shift_reg <= '0;
            sat_reg   <= 1'b0;
            vbuf      <= '0;
        end else begin
            if (beat_hs) begin
                if (final_lane) begin
                    lane_cnt <= '0;
                    vec_cnt  <= vec_cnt + B_N'(1);
                    state    <= IDLE;
                end else begin
                    lane_cnt <= lane_cnt + LW'(1);
                end
            end
            if (accept) begin
                vbuf     <= q_words;
                lane_cnt <= '0;
                state    <= DRAIN;
                if (first_acc) begin
                    dir_reg   <= dir_cfg;
                    shift_reg <= shift_amt;
                    sat_reg   <= |q_sat;
                end else begin
                    sat_reg <= sat_reg | (|q_sat);
                end
            end
        end
    end

    assign m_valid   = (state == DRAIN);
    assign m_data    = vbuf[lane_cnt];
    assign m_last    = m_valid && (vec_cnt == B_N'(N - 1)) && final_lane;
    assign m_vec_idx = vec_cnt;
    assign sat_flag  = sat_reg;
    assign busy      = (vec_cnt != '0) || (state == DRAIN);

endmodule
